// File: rtl/led_ctl_pkg.sv
// Shared state encoding and sizing helpers for the LED blink scheduler.
package led_ctl_pkg;

    localparam int CNT_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } led_state_e;

    // The phase timer counts down from (length-1), so $clog2 of the longest phase is enough.
    function automatic int timer_width(input int on_cyc, input int off_cyc, input int gap_cyc);
        int m;
        m = on_cyc;
        if (off_cyc > m) m = off_cyc;
        if (gap_cyc > m) m = gap_cyc;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/led_rr_pick.sv
// Combinational round-robin selector: first set request at or above pointer p, wrapping.
module led_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   p,
    output logic [NREQ-1:0] sel,
    output logic [PW-1:0]   index,
    output logic            valid
);

    always_comb begin
        sel   = '0;
        index = '0;
        valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (int'(p) + k) % NREQ;
            if (!valid && req[j]) begin
                valid  = 1'b1;
                sel[j] = 1'b1;
                index  = PW'(j);
            end
        end
    end

endmodule

// File: rtl/led_blink_sched.sv
// Time-shared LED blink scheduler: round-robin grant, exact on/off blink sequencing,
// one-cycle done pulse and a dead gap between grants. All outputs are registered.
module led_blink_sched
    import led_ctl_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int ON_CYC  = 12_500_000,
    parameter int OFF_CYC = 12_500_000,
    parameter int GAP_CYC = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CNT_W-1:0] cnt,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  led
);

    localparam int TW = timer_width(ON_CYC, OFF_CYC, GAP_CYC);
    localparam int PW = $clog2(NREQ);

    localparam logic [TW-1:0] ON_LD   = TW'(ON_CYC - 1);
    localparam logic [TW-1:0] OFF_LD  = TW'(OFF_CYC - 1);
    localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYC - 1);
    localparam logic [PW-1:0] PTR_TOP = PW'(NREQ - 1);

    led_state_e       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] blink_q, blink_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             busy_q, busy_d;
    logic             led_q, led_d;

    logic [NREQ-1:0]  pick_sel;
    logic [PW-1:0]    pick_idx;
    logic             pick_valid;
    logic [CNT_W-1:0] pick_cnt;

    led_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (req),
        .p     (ptr_q),
        .sel   (pick_sel),
        .index (pick_idx),
        .valid (pick_valid)
    );

    assign pick_cnt = cnt[pick_idx*CNT_W +: CNT_W];

    always_comb begin
        // NOTE: every _d gets a default before the case so no path infers a latch;
        // done_d defaults to zero, which is what makes done a single-cycle pulse.
        state_d = state_q;
        timer_d = timer_q;
        blink_d = blink_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        led_d   = led_q;
        busy_d  = busy_q;
        done_d  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    ptr_d   = (pick_idx == PTR_TOP) ? '0 : pick_idx + 1'b1;
                    owner_d = pick_idx;
                    blink_d = pick_cnt;
                    busy_d  = 1'b1;
                    if (pick_cnt != '0) begin
                        state_d = ST_ON;
                        timer_d = ON_LD;
                        grant_d = pick_sel;
                        led_d   = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                        timer_d = GAP_LD;
                        done_d  = pick_sel;
                    end
                end
            end

            ST_ON, ST_OFF: begin
                // A dropped request wins over phase expiry: abort never reports done.
                if (!req[owner_q]) begin
                    state_d = ST_GAP;
                    timer_d = GAP_LD;
                    blink_d = '0;
                    grant_d = '0;
                    led_d   = 1'b0;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (state_q == ST_ON) begin
                    state_d = ST_OFF;
                    timer_d = OFF_LD;
                    led_d   = 1'b0;
                end else if (blink_q == CNT_W'(1)) begin
                    state_d = ST_GAP;
                    timer_d = GAP_LD;
                    blink_d = '0;
                    grant_d = '0;
                    done_d  = grant_q;
                end else begin
                    state_d = ST_ON;
                    timer_d = ON_LD;
                    blink_d = blink_q - 1'b1;
                    led_d   = 1'b1;
                end
            end

            ST_GAP: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                grant_d = '0;
                led_d   = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            blink_q <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            blink_q <= blink_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            led_q   <= led_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign led   = led_q;

endmodule

// File: doc/led_blink_sched.md
# led_blink_sched

Time-shared LED blink scheduler. It arbitrates up to NREQ requesters for the board LED and grants them round-robin. For the granted requester it sequences an exact number of on/off blinks, then signals completion with a one-cycle done pulse. It sits between application logic and the `led` pin, driven by the `clk_25m` domain and the system reset.

## Interface

Parameters:
- NREQ, 4: number of requesters (2..8).
- CNT_W, 4: width of each blink-count field.
- ON_CYC, 12_500_000: clock cycles LED is on per blink (≥1).
- OFF_CYC, 12_500_000: clock cycles LED is off per blink (≥1).
- GAP_CYC, 25_000_000: dead cycles between consecutive grants (≥1).

Ports:
- clk  in  1  system clock (`clk_25m` in the top level).
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  level request per requester.
- cnt  in  NREQ*CNT_W  blink count; requester i uses bits [i*CNT_W +: CNT_W].
- grant  out  NREQ  one-hot; high while requester i owns the LED.
- done  out  NREQ  one-cycle pulse: sequence of requester i completed.
- busy  out  1  high in any state other than IDLE.
- led  out  1  LED drive, active-high.

## Operation

- States:
  - IDLE: LED free.
  - ON: LED lit.
  - OFF: LED dark.
  - GAP: dead time between grants.
- Reset: state IDLE, grant=0, done=0, busy=0, led=0, rr pointer=0, all counters 0.
- IDLE, no req: stays IDLE.
- IDLE, any req:
  - Pick the first set req[i] scanning from pointer p upward, wrapping.
  - Latch cnt[i] into the blink counter.
  - Set p = (i+1) mod NREQ.
- Selected cnt>0: grant[i]=1, led=1, enter ON with the phase timer loaded.
- Selected cnt=0: no grant and no LED activity; done[i] pulses; enter GAP.
- ON: lasts exactly ON_CYC cycles, then OFF.
- OFF: lasts exactly OFF_CYC cycles; then decrement the blink counter.
  - Counter nonzero: back to ON.
  - Counter zero: grant=0, done[i]=1 for one cycle, enter GAP.
- GAP: lasts exactly GAP_CYC cycles (the done cycle is the first GAP cycle), then IDLE. led=0 throughout.
- Abort: if req[i] drops while granted (ON or OFF):
  - Next cycle: grant=0, led=0, no done pulse, enter GAP.
  - The blink counter is discarded.
- cnt[i] is sampled only at selection; changes during the sequence are ignored.
- req[i] still high after its done pulse counts as a new request. It is served after every other pending requester (pointer already advanced).
- rst mid-sequence: next cycle all outputs return to reset values. No done pulse.
- At most one bit of grant is set and at most one bit of done is set. grant and done for the same requester are never high together.

## Timing

- req sampled high in IDLE at cycle T → grant and led rise at T+1.
- led high over cycles [T+1, T+ON_CYC], then low for OFF_CYC cycles; the pattern repeats cnt times.
- done pulse and grant fall at T+1+cnt*(ON_CYC+OFF_CYC).
- IDLE re-entered at T+1+cnt*(ON_CYC+OFF_CYC)+GAP_CYC; a request is sampled that cycle, with the next grant one cycle later.
- cnt=0: done at T+1; IDLE at T+1+GAP_CYC.
- Abort: req low at cycle A → grant and led low at A+1; IDLE at A+1+GAP_CYC.
- busy rises with the state leaving IDLE (T+1) and falls on return to IDLE.
- All outputs are registered; there are no combinational paths from req to any output.
- Phase timer width: $clog2(max(ON_CYC,OFF_CYC,GAP_CYC)).

## Structure

- Package `led_ctl_pkg` holds:
  - the state encodings (IDLE/ON/OFF/GAP);
  - the default CNT_W;
  - a function computing the timer width.
- Sub-module `led_rr_pick`: purely combinational round-robin selector.
  - Inputs: req, p.
  - Outputs: one-hot sel, index, valid.
  - Instantiated once.
- Top module holds the FSM, phase timer, blink counter, pointer and output registers.

## Test plan

Parameters for every scenario: ON_CYC=3, OFF_CYC=2, GAP_CYC=4, NREQ=4.
- Single request: req[1]=1, cnt[1]=2 at T.
  - grant=0010 over T+1..T+10; led high at T+1..T+3 and T+6..T+8.
  - done[1] at T+11; IDLE at T+15.
- Round-robin with all requesting: req=1111, all cnt=1, held until each done.
  - Grant order 0,1,2,3,0.
  - Successive grants start 10 cycles apart (5 sequence + 4 gap + 1 select).
- Zero count: req[2]=1, cnt[2]=0 at T.
  - done[2] at T+1; grant stays 0 and led stays 0; IDLE at T+5.
- Abort: req[0]=1, cnt=3; drop req[0] at T+4 (in OFF).
  - grant=0 and led=0 at T+5; no done pulse; IDLE at T+9.
- Reset mid-ON: rst=1 at T+2 of a granted sequence.
  - At T+3: grant=0, led=0, busy=0, done=0.
  - After release, req[3] is granted first from pointer 0 (req[0..2]=0, req[3]=1).
- Maximum count: cnt=15 with CNT_W=4.
  - Exactly 15 led rising edges; done at T+1+75.
